move_entry_ctrl: RTL

- Upstream stage of the tic-tac-toe game core. Turns three raw push-buttons (next, prev, confirm) into one validated move index 0..8.
- Synchronises and debounces the buttons, keeps a wrapping cursor, checks the chosen cell against the board occupancy vector, and offers the move over a valid/ready handshake.
- The game core consumes the offered move as its player position.

---
 rtl/move_entry_ctrl.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/move_entry_ctrl.sv
// move_entry_ctrl
//   Upstream stage of the tic-tac-toe game core. Conditions three raw
//   push-buttons (next, prev, confirm), keeps a wrapping cursor over the nine
//   cells, validates a confirmed cell against the board occupancy, and offers
//   the chosen cell to the game core over a valid/ready handshake.
//
// Ports:
//   clock        system clock, all flops on rising edge
//   reset        asynchronous, active-high reset
//   btn_next     raw async button, advance cursor
//   btn_prev     raw async button, retreat cursor
//   btn_confirm  raw async button, request move at cursor
//   enable       high while it is the player's turn; confirm ignored when low
//   occupied     occupancy vector, occupied[i]=1 means cell i is taken
//   move_ready   game core accepts the offered move
//   cursor       current cursor cell, 0..8
//   move_pos     offered cell index, valid while move_valid=1
//   move_valid   move offer, held until accepted
//   move_reject  one-cycle pulse: confirm hit an occupied cell
//   state        debug view of the FSM state (0=IDLE, 1=OFFER)
//
// Handshake: move_valid/move_pos form a standard valid/ready offer. Once
// move_valid rises, move_valid and move_pos hold unchanged until a rising
// edge samples move_ready=1; that edge is the transfer and move_valid falls
// on it. move_ready may be high before move_valid rises, in which case the
// transfer happens on the first edge with move_valid=1.

module move_entry_ctrl #(
    parameter int DEB_CYCLES = 16,
    parameter int DEB_W      = 20
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       btn_next,
    input  logic       btn_prev,
    input  logic       btn_confirm,
    input  logic       enable,
    input  logic [8:0] occupied,
    input  logic       move_ready,
    output logic [3:0] cursor,
    output logic [3:0] move_pos,
    output logic       move_valid,
    output logic       move_reject,
    output logic       state
);

    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } state_t;

    // Button index order: 0 = next, 1 = prev, 2 = confirm.
    logic [2:0] raw;
    logic [2:0] sync1;
    logic [2:0] sync2;
    logic [2:0] level;
    logic [2:0] level_d;
    logic [2:0] ev;

    assign raw = {btn_confirm, btn_prev, btn_next};

    for (genvar i = 0; i < 3; i++) begin : g_deb
        logic [DEB_W-1:0] cnt;

        // The counter measures how long the synchronised input has disagreed
        // with the debounced level. Once it has reached DEB_CYCLES the level
        // flips on the following edge, so a raw rise held stable produces an
        // event after DEB_CYCLES+3 edges (two synchroniser stages, DEB_CYCLES
        // counts, one flip edge).
        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                sync1[i]   <= 1'b0;
                sync2[i]   <= 1'b0;
                cnt        <= '0;
                level[i]   <= 1'b0;
                level_d[i] <= 1'b0;
            end else begin
                sync1[i]   <= raw[i];
                sync2[i]   <= sync1[i];
                level_d[i] <= level[i];
                if (sync2[i] == level[i]) begin
                    cnt <= '0;
                end else if (cnt == DEB_W'(DEB_CYCLES)) begin
                    level[i] <= ~level[i];
                    cnt      <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

    // Press events only: a one-cycle pulse on a debounced 0->1 transition.
    assign ev = level & ~level_d;

    logic ev_next;
    logic ev_prev;
    logic ev_confirm;

    assign ev_next    = ev[0];
    assign ev_prev    = ev[1];
    assign ev_confirm = ev[2];

    state_t st;

    assign state = st;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            st          <= IDLE;
            cursor      <= 4'd0;
            move_pos    <= 4'd0;
            move_valid  <= 1'b0;
            move_reject <= 1'b0;
        end else begin
            move_reject <= 1'b0;
            case (st)
                IDLE: begin
                    // An enabled confirm (accepted or rejected) swallows any
                    // navigation event of the same cycle.
                    if (ev_confirm && enable) begin
                        if (occupied[cursor]) begin
                            move_reject <= 1'b1;
                        end else begin
                            move_pos   <= cursor;
                            move_valid <= 1'b1;
                            st         <= OFFER;
                        end
                    end else if (ev_next && !ev_prev) begin
                        cursor <= (cursor == 4'd8) ? 4'd0 : cursor + 4'd1;
                    end else if (ev_prev && !ev_next) begin
                        cursor <= (cursor == 4'd0) ? 4'd8 : cursor - 4'd1;
                    end
                end
                OFFER: begin
                    // Button events are discarded here; the offer stays put
                    // regardless of enable or occupancy until accepted.
                    if (move_ready) begin
                        move_valid <= 1'b0;
                        st         <= IDLE;
                    end
                end
                default: begin
                    st         <= IDLE;
                    move_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
